mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// Responder side of the CPU memory interface: serves the controller's instruction-fetch port (1, read-only)
// and data port (2, read/write) from one shared single-port word array. A req/ack handshake with a
// programmable, fixed access latency replaces the controller's hard-coded wait states. Sits between the
// controller/datapath and the RAM; it is the only block that touches the memory array.
// PARAMETERS
// ADDR_W  11  word-address width; array depth = 2**ADDR_W words
// DATA_W  32  word width
// LAT     2   cycles from request acceptance to ack; legal range 1..15
// PORTS
// clk     in   1       clock, all state on rising edge
// rst_n   in   1       asynchronous reset, active low
// req1    in   1       fetch request (level), held until ack1
// addr1   in   ADDR_W  fetch word address
// rdata1  out  DATA_W  fetch read data, valid from ack1 cycle until next ack1
// ack1    out  1       one-cycle completion pulse, port 1
// req2    in   1       data request (level), held until ack2
// we2     in   1       1 = write (STR), 0 = read (LDR)
// addr2   in   ADDR_W  data word address
// wdata2  in   DATA_W  store data
// rdata2  out  DATA_W  load data, valid from ack2 cycle until next ack2 (unchanged by writes)
// ack2    out  1       one-cycle completion pulse, port 2
// busy    out  1       high while a transaction is in flight (BUSY or RESP)
// BEHAVIOUR
// - Reset (async assert): state IDLE; ack1=ack2=0; rdata1=rdata2=0; busy=0; last_grant=2; counter=0.
//   Array contents are not reset. In-flight transaction is aborted: no ack, no write commit.
// - FSM: IDLE -> BUSY on acceptance; BUSY -> RESP when counter reaches LAT-1 (LAT=1: IDLE -> RESP direct);
//   RESP -> IDLE unconditionally. Exactly one transaction in flight; no pipelining.
// - Acceptance: only in IDLE, at the edge where req1|req2 is high. addr, we2, wdata2 and the granted port
//   id are latched there; later input changes are ignored for that transaction.
// - Arbitration when req1 and req2 both high in IDLE: round-robin, grant the port not in last_grant;
//   last_grant updates on every acceptance. After reset port 1 wins the first tie.
// - Latency: accepted at edge t -> ackN high during cycle t+LAT exactly (one cycle), other ack stays 0.
// - Read: array read issued so that rdataN is updated at the same edge that raises ackN; rdataN then
//   holds until that port's next read ack. The other port's rdata is untouched.
// - Write: array written with latched wdata2 at the edge that raises ack2; a read of the same address
//   accepted afterwards returns the new value. rdata2 unchanged by a write.
// - RESP cycle never accepts: a requester still holding req in the ack cycle is not double-served; the
//   earliest new acceptance is the edge ending the cycle after ack. Requester must drop req after ack.
// - req dropped before ack: transaction still completes and acks (no abort).
// - busy = (state != IDLE), combinational from state.
// - Address arithmetic: addresses are word indices, no wrap or bounds logic needed (full ADDR_W decode).
// STRUCTURE
// - Package arm_mem_pkg: typedef enum logic [1:0] {MR_IDLE, MR_BUSY, MR_RESP} mr_state_t;
//   typedef enum logic {PORT_FETCH, PORT_DATA} mr_port_t; localparam DEF_MEM_LAT = 2.
// - One sub-module: mem_array (single-port synchronous RAM, DEPTH x DATA_W, en/we/addr/wdata/rdata,
//   1-cycle read), instantiated once; mem_responder holds FSM, arbiter, latency counter, output regs.
// TESTING
// - Reset: hold rst_n=0 with req1=1 -> ack1=ack2=busy=0, rdata1=rdata2=0; release -> accept next edge.
// - Write then read, LAT=2: req2 we2=1 addr2=0x010 wdata2=0xDEADBEEF -> ack2 at t+2; then req2 read
//   0x010 -> ack2 at t'+2 with rdata2=0xDEADBEEF; req1 addr1=0x010 -> rdata1=0xDEADBEEF.
// - Tie: req1 (addr 0x001) and req2 (addr 0x002) both high after reset -> port 1 acked first, port 2
//   accepted the cycle after ack1 and acked LAT+1 later; next tie grants port 2 first.
// - Holding req: req1 held high 3 cycles past ack1 -> exactly one extra transaction, never two acks
//   in consecutive cycles; busy low for exactly one cycle between transactions.
// - Reset mid-op: write to 0x020 value 0x12345678 over old 0x0; assert rst_n during BUSY -> no ack2,
//   later read of 0x020 returns 0x0.
// - Latency sweep LAT=1 and LAT=7: ack at exactly t+1 / t+7; rdata2 unchanged after a write ack.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, port ids, counter width
// and the round-robin pick used when both requesters ask in the same cycle.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_BUSY = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } mr_port_t;

    localparam int DEF_MEM_LAT = 2;
    localparam int CNT_W       = 4;   // holds LAT-1 for LAT up to 15

    // On a tie the port that did not win last time gets the grant.
    function automatic mr_port_t rr_pick(input logic r1, input logic r2,
                                         input mr_port_t last);
        if (r1 && r2) begin
            return (last == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        end else if (r1) begin
            return PORT_FETCH;
        end
        return PORT_DATA;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bus between the CPU memory controller (master) and the responder (slave).
//
// Handshake: reqN is a level held by the master until ackN. ackN is a single
// cycle pulse; rdataN is valid from the ack cycle until the next ackN of that
// port. The master must drop reqN after seeing ackN, otherwise the request is
// taken as a new transaction once the responder is idle again. Address and
// write data are captured at acceptance, so they may change afterwards.
interface mem_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    import arm_mem_pkg::*;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] rdata1;
    logic              ack1;
    logic              req2;
    logic              we2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata2;
    logic [DATA_W-1:0] rdata2;
    logic              ack2;
    logic              busy;
    mr_state_t         dbg_state;

    modport master (
        output req1, addr1, req2, we2, addr2, wdata2,
        input  rdata1, ack1, rdata2, ack2, busy, dbg_state
    );

    modport slave (
        input  req1, addr1, req2, we2, addr2, wdata2,
        output rdata1, ack1, rdata2, ack2, busy, dbg_state
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with one-cycle read latency.
// Read data only changes on a read access; writes leave it untouched.
module mem_array #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage access: write or read, never both in one cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Serves the fetch port (read-only) and the data port (read/write) from one
// shared RAM. One transaction at a time, fixed latency LAT from acceptance to
// ack. The RAM is accessed at the edge that enters RESP, so a read result is
// straight out of the RAM during the ack cycle and captured locally at the
// end of it, and a write commits exactly when the ack is raised.
module mem_responder
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LAT    = DEF_MEM_LAT   // 1..15
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    mr_state_t         state_q, state_d;
    mr_port_t          port_q, port_d;
    mr_port_t          last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;

    mr_port_t          grant;
    logic              mem_en_raw;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              ack1;
    logic              ack2;

    assign grant = rr_pick(bus.req1, bus.req2, last_grant_q);

    // Next state, request capture, latency count and RAM access strobe.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata1_d     = rdata1_q;
        rdata2_d     = rdata2_q;
        mem_en_raw   = 1'b0;
        mem_we       = we_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;

        case (state_q)
            MR_IDLE: begin
                if (bus.req1 || bus.req2) begin
                    port_d       = grant;
                    last_grant_d = grant;
                    addr_d       = (grant == PORT_FETCH) ? bus.addr1 : bus.addr2;
                    we_d         = (grant == PORT_DATA) && bus.we2;
                    wdata_d      = bus.wdata2;
                    if (LAT == 1) begin
                        // No wait cycles: access the RAM with the values being latched.
                        state_d    = MR_RESP;
                        cnt_d      = '0;
                        mem_en_raw = 1'b1;
                        mem_we     = we_d;
                        mem_addr   = addr_d;
                        mem_wdata  = wdata_d;
                    end else begin
                        state_d = MR_BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            MR_BUSY: begin
                if (cnt_q == LAT_M1) begin
                    state_d    = MR_RESP;
                    cnt_d      = '0;
                    mem_en_raw = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MR_RESP: begin
                // Never accepts here, so a still-held req is not served twice.
                state_d = MR_IDLE;
                if (!we_q) begin
                    if (port_q == PORT_FETCH) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata2_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase
    end

    // No RAM access while reset is asserted, so an aborted write never lands.
    assign mem_en = mem_en_raw && rst_n;

    // State and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MR_IDLE;
            port_q       <= PORT_FETCH;
            last_grant_q <= PORT_DATA;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata1_q     <= rdata1_d;
            rdata2_q     <= rdata2_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign ack1 = (state_q == MR_RESP) && (port_q == PORT_FETCH);
    assign ack2 = (state_q == MR_RESP) && (port_q == PORT_DATA);

    assign bus.ack1      = ack1;
    assign bus.ack2      = ack2;
    assign bus.rdata1    = ack1 ? mem_rdata : rdata1_q;
    assign bus.rdata2    = (ack2 && !we_q) ? mem_rdata : rdata2_q;
    assign bus.busy      = (state_q != MR_IDLE);
    assign bus.dbg_state = state_q;

endmodule
